// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: 8N1 UART transmitter that drains a show-ahead FIFO.
// Pops one byte in IDLE, shifts it out LSB first, and returns to IDLE.
// Optional build macro: PARITY_EN (adds an even-parity bit, 8E1 frame).
`timescale 1ns / 1ps

module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_rdata,
    output logic       fifo_re,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    // tx_done is registered, so it is set one clock ahead of the last stop clock
    localparam logic [BW-1:0] BAUD_PRE  = BW'(CLKS_PER_BIT - 2);

`ifdef PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state;
    logic [BW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;
    logic          baud_end;

    assign baud_end = (baud == BAUD_LAST);

    // Pop only from IDLE; reset and an empty FIFO both block the strobe
    assign fifo_re = (state == IDLE) && en && !fifo_empty && !rst;

    // Busy is a decode of the registered state, so it carries no input glitches
    assign tx_busy = (state != IDLE);

    // Frame sequencer: state, baud timing, bit index, line driver and done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            baud      <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            tx        <= 1'b1;
            tx_done   <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    baud    <= '0;
                    bit_idx <= '0;
                    tx      <= 1'b1;
                    if (fifo_re) begin
                        shift_reg <= fifo_rdata;
                        state     <= START;
                        tx        <= 1'b0;
                    end
                end

                START: begin
                    if (baud_end) begin
                        baud  <= '0;
                        state <= DATA;
                        tx    <= shift_reg[0];
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end

                DATA: begin
                    if (baud_end) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
`ifdef PARITY_EN
                            state   <= PARITY;
                            tx      <= ^shift_reg;
`else
                            state   <= STOP;
                            tx      <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shift_reg[bit_idx + 3'd1];
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end

`ifdef PARITY_EN
                PARITY: begin
                    if (baud_end) begin
                        baud  <= '0;
                        state <= STOP;
                        tx    <= 1'b1;
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
`endif

                STOP: begin
                    tx      <= 1'b1;
                    tx_done <= (baud == BAUD_PRE);
                    if (baud_end) begin
                        baud  <= '0;
                        state <= IDLE;
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                    baud  <= '0;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed + random bench for fifo_uart_tx at CLKS_PER_BIT=4.
// Contains a show-ahead FIFO model and a UART receiver model.
`timescale 1ns / 1ps

module tb_fifo_uart_tx;

    localparam int CPB = 4;
`ifdef PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_rdata = 8'h00;
    logic       fifo_re, tx, tx_busy, tx_done;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_re    (fifo_re),
        .tx         (tx),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // FIFO model
    logic [7:0] fq[$];
    bit         pop_pend = 1'b0;

    function automatic void refresh();
        fifo_empty = (fq.size() == 0);
        fifo_rdata = (fq.size() == 0) ? 8'h00 : fq[0];
    endfunction

    task automatic push(input logic [7:0] b);
        fq.push_back(b);
        refresh();
    endtask

    always @(posedge clk) begin
        #1;
        if (pop_pend) begin
            if (fq.size() > 0) void'(fq.pop_front());
            pop_pend = 1'b0;
        end
        refresh();
    end

    // Monitor and receiver model
    int         cyc = 0;
    bit         hist_tx   [0:32767];
    bit         hist_busy [0:32767];
    int         pop_cyc[$];
    logic [7:0] exp_q[$];
    int         n_done = 0, last_done = 0, viol = 0, n_rx = 0;
    bit         rx_busy = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_par = 1'b0;

    always @(negedge clk) begin
        cyc++;
        hist_tx[cyc & 32767]   = tx;
        hist_busy[cyc & 32767] = tx_busy;
        if (fifo_re && (fifo_empty || rst)) viol++;
        if (tx_done) begin
            n_done++;
            last_done = cyc;
        end
        if (fifo_re) begin
            pop_pend = 1'b1;
            pop_cyc.push_back(cyc);
            exp_q.push_back(fifo_rdata);
        end
        if (rst) begin
            rx_busy = 1'b0;
            exp_q.delete();
        end else if (!rx_busy) begin
            if (tx === 1'b0) begin
                rx_busy = 1'b1;
                rx_cnt  = 0;
            end
        end else begin
            rx_cnt++;
            for (int i = 0; i < 8; i++)
                if (rx_cnt == CPB * (1 + i) + CPB / 2) rx_byte[i] = tx;
`ifdef PARITY_EN
            if (rx_cnt == CPB * 9 + CPB / 2) rx_par = tx;
`endif
            if (rx_cnt == CPB * (NB - 1) + CPB / 2) begin
                check("rx_stop", tx, 1);
                if (exp_q.size() > 0) check("rx_byte", rx_byte, exp_q.pop_front());
                else check("rx_unexpected_frame", 1, 0);
`ifdef PARITY_EN
                check("rx_parity", rx_par, ^rx_byte);
`endif
                n_rx++;
                rx_busy = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_quiet(input int maxc, input string tag);
        int k = 0;
        while ((fq.size() != 0 || tx_busy || rx_busy || pop_pend) && k < maxc) begin
            tick();
            k++;
        end
        check({tag, "_timeout"}, (k >= maxc), 0);
        repeat (8) tick();
    endtask

    task automatic wait_pop(input int n, input string tag);
        int k = 0;
        while (pop_cyc.size() < n && k < 500) begin
            tick();
            k++;
        end
        check({tag, "_pop_timeout"}, (k >= 500), 0);
    endtask

    function automatic logic [3:0] hist4(input int a);
        return {hist_tx[a & 32767], hist_tx[(a + 1) & 32767],
                hist_tx[(a + 2) & 32767], hist_tx[(a + 3) & 32767]};
    endfunction

`ifdef PARITY_EN
    int exp_bits[NB] = '{0, 1, 0, 0, 0, 0, 1, 1, 0, 1, 1};
`else
    int exp_bits[NB] = '{0, 1, 0, 0, 0, 0, 1, 1, 0, 1};
`endif

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p, base_rx, base_done, cnt;
        logic allone;

        // Reset: outputs idle, no pop while rst even with data waiting
        rst = 1'b1;
        en  = 1'b1;
        repeat (3) tick();
        push(8'h61);
        @(negedge clk);
        check("rst_fifo_re", fifo_re, 0);
        check("rst_tx", tx, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_done", tx_done, 0);
        tick();
        rst = 1'b0;

        // Single byte 8'h61
        wait_pop(1, "single");
        p = pop_cyc[0];
        wait_quiet(300, "single");
        check("single_pops", pop_cyc.size(), 1);
        check("single_done_cnt", n_done, 1);
        check("single_done_lat", last_done - p, FRAME);
        cnt = 0;
        for (int c = p; c <= p + FRAME + 3; c++) cnt += int'(hist_busy[c & 32767]);
        check("single_busy_len", cnt, FRAME);
        for (int k = 0; k < NB; k++)
            check($sformatf("single_bit%0d", k), hist4(p + 1 + CPB * k),
                  (exp_bits[k] != 0) ? 4'b1111 : 4'b0000);
        check("single_rx", n_rx, 1);

        // Back-to-back 61,62,63
        pop_cyc.delete();
        base_rx = n_rx;
        push(8'h61);
        push(8'h62);
        push(8'h63);
        wait_quiet(600, "b2b");
        check("b2b_pops", pop_cyc.size(), 3);
        if (pop_cyc.size() == 3) begin
            check("b2b_gap1", pop_cyc[1] - pop_cyc[0], FRAME + 1);
            check("b2b_gap2", pop_cyc[2] - pop_cyc[1], FRAME + 1);
        end
        check("b2b_rx", n_rx - base_rx, 3);

        // Enable gating: en low blocks the pop
        pop_cyc.delete();
        base_rx = n_rx;
        en = 1'b0;
        push(8'h55);
        allone = 1'b1;
        repeat (20) begin
            @(negedge clk);
            allone &= tx;
        end
        tick();
        check("gate_no_pop", pop_cyc.size(), 0);
        check("gate_tx_idle", allone, 1);
        en = 1'b1;
        wait_pop(1, "gate");
        repeat (9) tick();
        en = 1'b0;
        push(8'h5A);
        base_done = n_done;
        cnt = 0;
        while (tx_busy && cnt < 200) begin
            tick();
            cnt++;
        end
        repeat (60) tick();
        check("gate_frame_done", n_done - base_done, 1);
        check("gate_one_pop", pop_cyc.size(), 1);
        check("gate_fifo_left", fq.size(), 1);
        check("gate_rx", n_rx - base_rx, 1);
        en = 1'b1;
        wait_quiet(300, "gate_drain");
        check("gate_drain_rx", n_rx - base_rx, 2);

        // Reset during DATA bit 3 of 8'hAA, then 8'h3C sent cleanly
        pop_cyc.delete();
        base_rx = n_rx;
        push(8'hAA);
        wait_pop(1, "rstmid");
        push(8'h3C);
        repeat (17) tick();
        @(negedge clk);
        check("rstmid_busy_before", tx_busy, 1);
        check("rstmid_bit3", tx, 1);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_re_low", fifo_re, 0);
        tick();
        @(negedge clk);
        check("rstmid_tx", tx, 1);
        check("rstmid_busy", tx_busy, 0);
        tick();
        rst = 1'b0;
        wait_quiet(300, "rstmid");
        check("rstmid_pops", pop_cyc.size(), 2);
        check("rstmid_rx", n_rx - base_rx, 1);

`ifdef PARITY_EN
        // Parity bit values and frame length
        pop_cyc.delete();
        push(8'h07);
        wait_quiet(300, "par07");
        check("par07_bit", rx_par, 1);
        if (pop_cyc.size() > 0) check("par07_len", last_done - pop_cyc[0], 44);
        push(8'h03);
        wait_quiet(300, "par03");
        check("par03_bit", rx_par, 0);
`endif

        // Random bytes at random times
        base_rx = n_rx;
        for (int i = 0; i < 256; i++) begin
            push(8'($urandom_range(0, 255)));
            repeat ($urandom_range(0, 60)) tick();
        end
        wait_quiet(20000, "rand");
        check("rand_rx", n_rx - base_rx, 256);

        check("re_while_empty_or_rst", viol, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
